// File: rtl/universal_shift_register.sv
// N-bit universal shift register: hold, shift left/right, parallel load.
// Serial outputs at both ends, saturating shift counter with FULL flag.
module universal_shift_register #(
  parameter int          N    = 8,
  parameter logic [N-1:0] INIT = '0,
  parameter int          CW   = $clog2(N+1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CE,
  input  logic [1:0]    MODE,
  input  logic          SI_L,
  input  logic          SI_R,
  input  logic [N-1:0]  D,
  output logic [N-1:0]  Q,
  output logic          SO_L,
  output logic          SO_R,
  output logic [CW-1:0] CNT,
  output logic          FULL
);

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHL  = 2'b01,
    SHR  = 2'b10,
    LOAD = 2'b11
  } mode_t;

  logic [N-1:0]  shl;
  logic [N-1:0]  shr;
  logic [CW-1:0] cnt_inc;

  // A one-bit register has no neighbours; the serial input replaces it.
  generate
    if (N == 1) begin : g_one
      assign shl = SI_L;
      assign shr = SI_R;
    end else begin : g_many
      assign shl = {Q[N-2:0], SI_L};
      assign shr = {SI_R, Q[N-1:1]};
    end
  endgenerate

  assign FULL    = (CNT == CW'(N));
  assign cnt_inc = FULL ? CNT : CNT + CW'(1);
  assign SO_L    = Q[N-1];
  assign SO_R    = Q[0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      Q   <= INIT;
      CNT <= '0;
    end else if (CE) begin
      case (mode_t'(MODE))
        SHL: begin
          Q   <= shl;
          CNT <= cnt_inc;
        end
        SHR: begin
          Q   <= shr;
          CNT <= cnt_inc;
        end
        LOAD: begin
          Q   <= D;
          CNT <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register.
// Covers N=8 (INIT=8'h3C) and the N=1 boundary.
module tb_universal_shift_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ce, sil, sir;
  logic [1:0] mode;
  logic [7:0] d;
  logic [7:0] q;
  logic       sol, sor, full;
  logic [3:0] cnt;

  logic       rst1, ce1, sil1, sir1;
  logic [1:0] mode1;
  logic       d1;
  logic       q1;
  logic       sol1, sor1, full1;
  logic       cnt1;

  universal_shift_register #(
    .N(8), .INIT(8'h3C)
  ) dut (
    .CLK(clk), .RESET(rst), .CE(ce), .MODE(mode),
    .SI_L(sil), .SI_R(sir), .D(d), .Q(q),
    .SO_L(sol), .SO_R(sor), .CNT(cnt), .FULL(full)
  );

  universal_shift_register #(
    .N(1), .INIT(1'b0)
  ) dut1 (
    .CLK(clk), .RESET(rst1), .CE(ce1), .MODE(mode1),
    .SI_L(sil1), .SI_R(sir1), .D(d1), .Q(q1),
    .SO_L(sol1), .SO_R(sor1), .CNT(cnt1), .FULL(full1)
  );

  typedef struct {
    logic [7:0] q;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq;
  int         mcnt;
  int         passed = 0;
  int         total  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, want);
  endtask

  task automatic step(input logic r, input logic c,
                      input logic [1:0] m, input logic l,
                      input logic rr, input logic [7:0] dd);
    exp_t e;
    rst = r; ce = c; mode = m; sil = l; sir = rr; d = dd;
    if (r) begin
      mq = 8'h3C; mcnt = 0;
    end else if (c) begin
      if (m == 2'b01) begin
        mq = (mq << 1) | {7'd0, l};
        mcnt = (mcnt < 8) ? mcnt + 1 : 8;
      end else if (m == 2'b10) begin
        mq = (mq >> 1) | {l ? 1'b0 : 1'b0, 7'd0} | {rr, 7'd0};
        mcnt = (mcnt < 8) ? mcnt + 1 : 8;
      end else if (m == 2'b11) begin
        mq = dd; mcnt = 0;
      end
    end
    e.q = mq; e.cnt = 4'(mcnt);
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("q",    32'(q),    32'(e.q));
    check("cnt",  32'(cnt),  32'(e.cnt));
    check("full", 32'(full), 32'(e.cnt == 4'd8));
    check("so_l", 32'(sol),  32'(e.q[7]));
    check("so_r", 32'(sor),  32'(e.q[0]));
  endtask

  task automatic step1(input logic r, input logic [1:0] m,
                       input logic l, input logic rr,
                       input logic wq, input logic wc);
    rst1 = r; ce1 = 1'b1; mode1 = m;
    sil1 = l; sir1 = rr; d1 = 1'b0;
    @(posedge clk); #1;
    check("n1_q",    32'(q1),    32'(wq));
    check("n1_cnt",  32'(cnt1),  32'(wc));
    check("n1_full", 32'(full1), 32'(wc));
    check("n1_so",   32'(sol1),  32'(sor1));
  endtask

  logic [7:0] piso_bits;
  logic [7:0] sipo_bits;

  initial begin
    rst = 1'b0; ce = 1'b0; mode = 2'b00;
    sil = 1'b0; sir = 1'b0; d = 8'h00;
    mq = 8'h00; mcnt = 0;
    rst1 = 1'b0; ce1 = 1'b0; mode1 = 2'b00;
    sil1 = 1'b0; sir1 = 1'b0; d1 = 1'b0;
    @(posedge clk); #1;

    // reset wins over CE=0 and a pending load
    step(1, 0, 2'b11, 0, 0, 8'hFF);
    check("rst_q", 32'(q), 32'h3C);
    check("rst_cnt", 32'(cnt), 32'd0);

    // SISO: bit appears on SO_L after exactly 8 shifts
    step(0, 1, 2'b11, 1'bx, 1'bx, 8'h00);
    step(0, 1, 2'b01, 1, 0, 8'hxx);
    for (int i = 2; i <= 9; i++) begin
      step(0, 1, 2'b01, 0, 0, 8'hxx);
      check("siso_sol", 32'(sol), 32'(i == 8));
    end
    check("siso_full", 32'(full), 32'd1);

    // PISO: load A5, shift right, LSB first
    piso_bits = 8'hA5;
    step(0, 1, 2'b11, 1'bx, 1'bx, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      check("piso_sor", 32'(sor), 32'(piso_bits[i]));
      step(0, 1, 2'b10, 1'bx, 0, 8'hxx);
    end
    check("piso_q", 32'(q), 32'h00);

    // SIPO then saturation
    sipo_bits = 8'b1101_0010;
    step(0, 1, 2'b11, 1'bx, 1'bx, 8'h00);
    for (int i = 7; i >= 0; i--)
      step(0, 1, 2'b01, sipo_bits[i], 1'bx, 8'hxx);
    check("sipo_q", 32'(q), 32'hD2);
    step(0, 1, 2'b01, 0, 1'bx, 8'hxx);
    step(0, 1, 2'b01, 0, 1'bx, 8'hxx);
    check("sat_q", 32'(q), 32'h48);
    check("sat_cnt", 32'(cnt), 32'd8);

    // CE gating, then reset under CE=0, then load
    step(0, 1, 2'b11, 1'bx, 1'bx, 8'h96);
    step(0, 1, 2'b01, 1, 1'bx, 8'hxx);
    step(0, 1, 2'b10, 1'bx, 1, 8'hxx);
    for (int i = 0; i < 3; i++)
      step(0, 0, 2'b01, 1, 1, 8'hFF);
    check("ce_cnt", 32'(cnt), 32'd2);
    step(1, 0, 2'b01, 1, 1, 8'hFF);
    check("ce_rst_q", 32'(q), 32'h3C);
    step(0, 1, 2'b11, 1'bx, 1'bx, 8'h5A);
    check("load_q", 32'(q), 32'h5A);
    step(0, 1, 2'b00, 1, 1, 8'hFF);

    // N=1 boundary
    step1(1, 2'b00, 0, 0, 0, 0);
    step1(0, 2'b01, 1, 1'bx, 1, 1);
    step1(0, 2'b10, 1'bx, 0, 0, 1);
    step1(0, 2'b11, 1'bx, 1'bx, 0, 0);

    if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the fixed 8-stage serial-in/serial-out chain: an N-bit shift register with clock enable and synchronous reset.
- Runtime-selectable hold, shift-left, shift-right and parallel-load modes.
- Serial outputs at both ends, plus a saturating shift counter with a FULL flag.
- Used as SISO delay line, SIPO deserialiser or PISO serialiser in serial links and LED/SPI style drivers.

Parameters:
N, 8, register width in bits; legal range N >= 1
INIT, 0, N-bit value loaded into Q on RESET
CW, $clog2(N+1), width of CNT; derived, not to be overridden

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous reset, active-high
CE  input  1  clock enable; when 0, all state holds
MODE  input  2  00 hold, 01 shift left (toward MSB), 10 shift right (toward LSB), 11 parallel load
SI_L  input  1  serial input entering Q[0] on shift left
SI_R  input  1  serial input entering Q[N-1] on shift right
D  input  N  parallel load data
Q  output  N  register contents
SO_L  output  1  Q[N-1], serial output for left-shift chains
SO_R  output  1  Q[0], serial output for right-shift chains
CNT  output  CW  shifts performed since last load or reset, saturating at N
FULL  output  1  CNT == N

Behaviour:
- Fully registered state: Q and CNT. SO_L, SO_R and FULL are combinational decodes of registers. No combinational path from any input to any output.
- Reset values (after RESET sampled high at an edge): Q = INIT, CNT = 0, FULL = 0, SO_L = INIT[N-1], SO_R = INIT[0].
- Priority at each rising CLK edge: RESET > CE == 0 > MODE.
- RESET = 1: reset values are applied regardless of CE, MODE or D.
- CE = 0 (RESET = 0): Q and CNT hold.
- MODE 00: Q and CNT hold.
- MODE 01: Q <= {Q[N-2:0], SI_L}; CNT <= min(CNT+1, N).
- MODE 10: Q <= {SI_R, Q[N-1:1]}; CNT <= min(CNT+1, N).
- MODE 11: Q <= D; CNT <= 0.
- Latency:
  - A bit applied on SI_L appears at SO_L after exactly N enabled left-shift edges. With CE tied high and MODE = 01, this is identical to an N-stage flip-flop chain.
  - Parallel-loaded data is visible on Q one edge after the load.
- N = 1:
  - Shift left takes Q <= SI_L; shift right takes Q <= SI_R.
  - SO_L and SO_R are the same bit; CW = 1.
  - FULL asserts after the first shift.
- CNT saturation: once CNT == N, further shifts keep CNT = N and FULL = 1; Q keeps shifting. Only a load or RESET clears CNT.
- Mode changes take effect on the very next enabled edge; no pipeline to drain. A direction change mid-frame continues counting from the current CNT.
- RESET mid-shift discards contents. Q = INIT on the next edge, independent of in-flight data.
- X on D or SI_* is permitted whenever the corresponding mode is not selected, and must not propagate into Q.

Test Plan:
- Reset: N=8, INIT=8'h3C, hold RESET 1 edge with CE=0 and MODE=11, D=8'hFF -> Q=8'h3C, CNT=0, FULL=0, SO_L=0, SO_R=0.
- SISO delay: N=8, INIT=0, CE=1, MODE=01, SI_L=1 for one edge then 0 -> SO_L low for edges 1-7, high after edge 8 only, low after edge 9; CNT=8 and FULL=1 from edge 8.
- PISO: MODE=11 with D=8'hA5, then MODE=10, SI_R=0 for 8 edges -> SO_R sampled before each shift reads 1,0,1,0,0,1,0,1; after the 8 shifts Q=8'h00 and FULL=1.
- SIPO plus saturation: MODE=01, drive SI_L with 1,1,0,1,0,0,1,0 over 8 edges -> Q=8'hD2, FULL=1. Two further shifts with SI_L=0 -> CNT stays 8, Q=8'h48.
- CE gating and priority:
  - Mid-shift, drop CE for 3 edges -> Q and CNT frozen.
  - Then CE=0 with RESET=1 -> Q=INIT, CNT=0.
  - Then MODE=11, CE=1, D=8'h5A -> Q=8'h5A, CNT=0.
- N=1 boundary: MODE=01 with SI_L=1 -> Q=1, FULL=1. Then MODE=10 with SI_R=0 -> Q=0, CNT stays 1.
